// File: rtl/seg_display_scheduler.sv
// Four-digit multiplexed seven-segment scan controller. Each frame holds four digit
// slots with dead-time, PWM brightness, blanking, zero suppression and frame-aligned loads.
module seg_display_scheduler #(
    parameter int SLOT_W = 10,
    parameter int GAP    = 16
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        lz_suppress,
    input  logic [2:0]  brightness,
    input  logic        load_req,
    output logic        load_ack,
    output logic [3:0]  an_out,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic        frame_start
);

    typedef enum logic [1:0] {
        PH_GAP,
        PH_ON,
        PH_OFF
    } phase_t;

    localparam logic [SLOT_W-1:0] SLOT_LAST = '1;
    localparam logic [SLOT_W-1:0] GAP_CNT   = SLOT_W'(GAP);

    logic [SLOT_W-1:0] slot_cnt;
    logic [1:0]        digit;
    logic [15:0]       shadow_value;
    logic [3:0]        shadow_dp;
    logic [3:0]        shadow_blank;
    logic              shadow_lz;
    logic [2:0]        shadow_bright;
    logic              frame_end;
    phase_t            phase;
    logic [3:0]        nibble;
    logic [3:0]        lz_mask;
    logic              digit_lit;
    logic [3:0]        an_nxt;
    logic [6:0]        seg_nxt;
    logic              dp_nxt;

    // Active-low segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign frame_end = (digit == 2'd3) && (slot_cnt == SLOT_LAST);

    always_ff @(posedge clock_in or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            slot_cnt <= '0;
            digit    <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (slot_cnt == SLOT_LAST) begin
                digit <= digit + 1'b1;
            end
        end
    end

    // Shadow copy only changes on the frame-end edge, so a frame never mixes old and new data.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            shadow_value  <= '0;
            shadow_dp     <= '0;
            shadow_blank  <= '0;
            shadow_lz     <= 1'b0;
            shadow_bright <= '0;
        end else if (frame_end && load_req) begin
            shadow_value  <= value_in;
            shadow_dp     <= dp_in;
            shadow_blank  <= blank_in;
            shadow_lz     <= lz_suppress;
            shadow_bright <= brightness;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        phase = PH_OFF;
        if (slot_cnt < GAP_CNT) begin
            phase = PH_GAP;
        end else if (slot_cnt[SLOT_W-1 -: 3] <= shadow_bright) begin
            phase = PH_ON;
        end

        nibble = shadow_value[{digit, 2'b00} +: 4];

        // A digit is a leading zero when it and every digit to its left are zero.
        lz_mask = '0;
        if (shadow_lz) begin
            lz_mask[3] = (shadow_value[15:12] == 4'h0);
            lz_mask[2] = lz_mask[3] && (shadow_value[11:8] == 4'h0);
            lz_mask[1] = lz_mask[2] && (shadow_value[7:4] == 4'h0);
        end

        digit_lit = (phase == PH_ON) && !shadow_blank[digit] && !lz_mask[digit];
        an_nxt    = digit_lit ? ~(4'b0001 << digit) : 4'hF;
        seg_nxt   = shadow_blank[digit] ? 7'h7F : hex_to_seg(nibble);
        dp_nxt    = !(digit_lit && shadow_dp[digit]);
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            an_out      <= 4'hF;
            seg_out     <= 7'h7F;
            dp_out      <= 1'b1;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            an_out      <= an_nxt;
            seg_out     <= seg_nxt;
            dp_out      <= dp_nxt;
            load_ack    <= frame_end && load_req;
            frame_start <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler: load requests queue their expected shadow contents, and a
// monitor rebuilds every pin value from the display rules and compares slot by slot.
`timescale 1ns/1ps
module tb_seg_display_scheduler;

    localparam int SLOT_W = 10;
    localparam int GAP    = 16;
    localparam int SLOT   = 1 << SLOT_W;
    localparam int FRAME  = 4 * SLOT;

    localparam logic [6:0] HEX_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
        logic [2:0]  bright;
        int          issue_n;
    } cfg_t;

    logic        clock_in = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        lz_suppress = 1'b0;
    logic [2:0]  brightness = '0;
    logic        load_req = 1'b0;
    logic        load_ack;
    logic [3:0]  an_out;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic        frame_start;

    cfg_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   n = 0;          // rising edges since reset release, maintained by the monitor

    seg_display_scheduler #(.SLOT_W(SLOT_W), .GAP(GAP)) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .value_in    (value_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .lz_suppress (lz_suppress),
        .brightness  (brightness),
        .load_req    (load_req),
        .load_ack    (load_ack),
        .an_out      (an_out),
        .seg_out     (seg_out),
        .dp_out      (dp_out),
        .frame_start (frame_start)
    );

    always #20 clock_in = ~clock_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected {an, seg, dp} for frame position s under configuration c.
    function automatic logic [11:0] exp_pins(input cfg_t c, input int s);
        int d, cnt, nib;
        bit hidden, lit;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        d      = s / SLOT;
        cnt    = s % SLOT;
        nib    = int'((c.value >> (4 * d)) & 16'hF);
        hidden = c.blank[d] || (c.lz && d > 0 && (c.value >> (4 * d)) == 16'h0);
        lit    = !hidden && cnt >= GAP && cnt < (int'(c.bright) + 1) * (SLOT / 8);
        an = 4'hF;
        if (lit) an[d] = 1'b0;
        seg = c.blank[d] ? 7'h7F : HEX_TAB[nib];
        dp  = !(lit && c.dp[d]);
        return {an, seg, dp};
    endfunction

    // Monitor: pins at the n-th falling edge reflect the scan position of edge n-1.
    initial begin
        cfg_t       cur;
        int         s, bad_cnt;
        bit         slot_bad, exp_fs, exp_ack;
        logic [11:0] e, a, bad_a, bad_e;
        cur = '{default: '0};
        slot_bad = 0;
        bad_cnt = 0;
        bad_a = '0;
        bad_e = '0;
        forever begin
            @(negedge clock_in);
            if (!reset) begin
                n = 0;
                cur = '{default: '0};
                slot_bad = 0;
                exp_q.delete();
            end else begin
                n++;
                s = (n - 1) % FRAME;
                e = exp_pins(cur, s);
                a = {an_out, seg_out, dp_out};
                if (a !== e && !slot_bad) begin
                    slot_bad = 1;
                    bad_cnt = s % SLOT;
                    bad_a = a;
                    bad_e = e;
                end
                if (s % SLOT == SLOT - 1) begin
                    checks++;
                    if (slot_bad) begin
                        failures++;
                        $display("FAIL slot digit %0d at edge %0d, slot clock %0d: {an,seg,dp}=0x%03h expected 0x%03h",
                                 s / SLOT, n, bad_cnt, bad_a, bad_e);
                    end
                    slot_bad = 0;
                end
                exp_fs  = (n % FRAME == 0);
                exp_ack = exp_fs && exp_q.size() > 0 && exp_q[0].issue_n + 2 <= n;
                if (exp_fs || frame_start) check("frame_start", frame_start, exp_fs);
                if (exp_ack || load_ack) check("load_ack", load_ack, exp_ack);
                if (exp_ack) cur = exp_q.pop_front();
            end
        end
    end

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic goto_pos(input int p);
        int w;
        w = 0;
        while (n % FRAME != p && w < FRAME + 4) begin
            tick();
            w++;
        end
    endtask

    task automatic raise(input cfg_t c);
        value_in    = c.value;
        dp_in       = c.dp;
        blank_in    = c.blank;
        lz_suppress = c.lz;
        brightness  = c.bright;
        load_req    = 1'b1;
        c.issue_n   = n;
        exp_q.push_back(c);
    endtask

    task automatic wait_ack(input string name);
        int w;
        w = 0;
        while (!load_ack && w < 2 * FRAME + 8) begin
            tick();
            w++;
        end
        if (!load_ack) begin
            checks++;
            failures++;
            $display("FAIL %s: no load_ack within %0d clocks", name, w);
        end
    endtask

    task automatic load(input cfg_t c, input string name);
        raise(c);
        wait_ack(name);
        load_req = 1'b0;
        repeat ($urandom_range(200, 2500)) tick();
    endtask

    function automatic cfg_t mk(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                                input logic lz, input logic [2:0] br);
        cfg_t c;
        c.value = v;
        c.dp = dp;
        c.blank = bl;
        c.lz = lz;
        c.bright = br;
        c.issue_n = 0;
        return c;
    endfunction

    initial begin
        int  t_ack1, w;
        bit  saw_ack;
        cfg_t c;

        // Reset values while reset is held
        tick();
        tick();
        check("reset an_out", an_out, 4'hF);
        check("reset seg_out", seg_out, 7'h7F);
        check("reset dp_out", dp_out, 1'b1);
        check("reset load_ack", load_ack, 1'b0);
        check("reset frame_start", frame_start, 1'b0);
        @(negedge clock_in);
        #1 reset = 1'b1;

        load(mk(16'h12AF, 4'h0, 4'h0, 1'b0, 3'd7), "ack 12AF b7");
        load(mk(16'h12AF, 4'h0, 4'h0, 1'b0, 3'd0), "ack 12AF b0");
        load(mk(16'h0005, 4'h0, 4'h0, 1'b1, 3'd5), "ack lz 0005");
        load(mk(16'h0000, 4'h0, 4'h0, 1'b1, 3'd7), "ack lz 0000");

        // Request withdrawn before frame end: nothing captured, no ack
        c = mk(16'hBEEF, 4'hF, 4'h0, 1'b0, 3'd3);
        raise(c);
        repeat (1500) tick();
        load_req = 1'b0;
        void'(exp_q.pop_back());
        saw_ack = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            saw_ack |= load_ack;
        end
        check("no ack for withdrawn request", saw_ack, 1'b0);

        // Held request raised during digit 1: two acks exactly one frame apart
        goto_pos(SLOT + 200);
        raise(mk(16'hFFFF, 4'h0, 4'h0, 1'b0, 3'd7));
        wait_ack("ack FFFF first");
        t_ack1 = n;
        c = mk(16'hFFFF, 4'h0, 4'h0, 1'b0, 3'd7);
        c.issue_n = n;
        exp_q.push_back(c);
        tick();
        wait_ack("ack FFFF second");
        check("ack spacing", n - t_ack1, FRAME);
        load_req = 1'b0;
        repeat (300) tick();

        load(mk(16'h4321, 4'b1001, 4'b1000, 1'b0, 3'd4), "ack blank/dp");
        for (int i = 0; i < 3; i++) begin
            load(mk(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 3'($urandom)), "ack random");
        end

        // Reset mid digit-2 slot with a request pending
        goto_pos(2 * SLOT + 300);
        raise(mk(16'h9999, 4'h0, 4'h0, 1'b0, 3'd7));
        #5 reset = 1'b0;
        load_req = 1'b0;
        #1;
        check("async reset an_out", an_out, 4'hF);
        check("async reset load_ack", load_ack, 1'b0);
        check("async reset dp_out", dp_out, 1'b1);
        repeat (3) @(negedge clock_in);
        #1 reset = 1'b1;
        w = 0;
        while (an_out == 4'hF && w < SLOT + 8) begin
            tick();
            w++;
        end
        check("first anode after reset", an_out, 4'hE);
        check("first seg after reset", seg_out, 7'h40);
        repeat (FRAME + 10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(90000 * 40);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
Frame-based scan controller for the 4-digit multiplexed seven-segment display.
- Sequences digit selection, applies ghosting dead-time, per-digit blanking, leading-zero suppression and PWM brightness.
- Accepts new display data through a req/ack handshake applied only at frame boundaries, so a frame never mixes old and new digits.
- Sits between the system register/bus logic and the display pins, clocked from the nominal 25 MHz system clock.

Parameters:
- SLOT_W, 10, slot counter width; one digit slot = 2^SLOT_W clocks (1024 clocks ≈ 24.4 kHz digit rate at 25 MHz).
- GAP, 16, dead-time clocks at start of each slot with all anodes off; legal range 1..2^(SLOT_W-3)-1.

Ports:
- clock_in  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- value_in  input  16  four hex nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
- dp_in  input  4  decimal point enables, bit k = digit k.
- blank_in  input  4  force digit k fully off (segments and dp).
- lz_suppress  input  1  enable leading-zero suppression.
- brightness  input  3  PWM level 0..7.
- load_req  input  1  level request to capture value_in/dp_in/blank_in/lz_suppress/brightness.
- load_ack  output  1  one-cycle pulse: inputs captured on this edge.
- an_out  output  4  anode enables, active-low.
- seg_out  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_out  output  1  decimal point, active-low.
- frame_start  output  1  one-cycle pulse at start of digit-0 slot.

Behaviour:
- Reset (reset=0, asynchronous), immediately and for as long as held:
  - an_out=4'hF, seg_out=7'h7F, dp_out=1, load_ack=0, frame_start=0.
  - Slot counter=0, digit index=0, all shadow registers=0.
- Counters:
  - slot_cnt counts 0..2^SLOT_W-1, wrapping.
  - digit index (2 bits) increments on slot_cnt wrap, 3→0.
  - One frame = 4 slots = 4096 clocks.
- Per-slot phases, decoded from slot_cnt:
  - GAP: slot_cnt < GAP. All anodes off.
  - ON: slot_cnt ≥ GAP and slot_cnt[SLOT_W-1:SLOT_W-3] ≤ brightness. Selected anode on unless the digit is blanked.
  - OFF: otherwise. All anodes off.
  - brightness=7 gives ON for clocks GAP..1023; brightness=0 gives ON for GAP..127.
- Output timing: all outputs are registered, with exactly 1 clock latency from counter state to pins.
  - Example: slot_cnt==GAP in cycle n gives an_out active in cycle n+1.
- Segment decode: standard hex 0–F from the selected shadow nibble.
  - seg_out is driven in all phases.
  - dp_out = ~shadow_dp[k] during ON, 1 otherwise.
- Leading-zero suppression (shadow_lz=1): digit k (k=3,2,1) is suppressed when nibbles k..3 are all zero.
  - Suppressed digit: anode stays off; its dp is lost with it.
  - Digit 0 is never suppressed.
- Blanking: shadow_blank[k]=1 keeps anode k off for the whole slot. Blanking overrides everything else.
- Load handshake:
  - The frame-end cycle is digit 3 with slot_cnt = 2^SLOT_W-1.
  - If load_req=1 sampled in the frame-end cycle, all inputs are captured into shadow registers on that edge and load_ack pulses high for the following single cycle.
  - The new data is displayed from the next frame's digit-0 slot onward.
  - The requester holds load_req and data stable until it sees load_ack.
  - If load_req drops before frame end, nothing is captured and no ack is issued.
  - If load_req is still high after the ack, the next capture happens at the next frame end; there is never more than one ack per frame.
- frame_start: registered pulse in the cycle where digit index=0 and slot_cnt=0 appear (same cycle as load_ack).
- Reset mid-operation: outputs go off asynchronously, any pending request is dropped, and the shadow registers clear. After release the scan restarts at digit 0, slot 0.

Test Plan:
1. Load value 0x12AF, brightness 7, lz 0, blank 0:
   - Next frame: an_out 1110/1101/1011/0111 in successive slots.
   - Each anode is low only for slot clocks 17..1024 (1-cycle latency).
   - seg_out = 0x0E (F), 0x08 (A), 0x24 (2), 0x79 (1).
2. Brightness 0, same value: each anode is low for exactly 112 clocks per slot, starting 17 clocks after slot start.
3. lz_suppress=1, value 0x0005: only an_out=1110 ever asserted, seg_out 0x12. Then value 0x0000: digit 0 shows 0x40; digits 1–3 stay off.
4. load_req raised during digit 1 slot with new value 0xFFFF:
   - No display change mid-frame.
   - load_ack exactly one cycle after digit-3 slot_cnt 1023, coincident with frame_start.
   - Next digit-0 slot shows 0x0E.
   - With load_req held, a second ack appears exactly 4096 clocks later.
5. blank_in=4'b1000, dp_in=4'b1001: an_out[3] never low; dp_out low only during digit-0 ON phase.
6. Assert reset mid-slot of digit 2: an_out=4'hF the same cycle (asynchronously) with load_ack=0. After release, the first active anode is 1110 and seg_out=0x40 (shadow value 0).
